// File: rtl/semalock_master_if.sv
// Bus port between semalock_master and the semaphore memory slave.
// Wishbone-style classic cycle: cyc/stb/we/adr/dat out, ack/dat in.
interface semalock_master_if;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [13:0] adr_o;
    logic [31:0] dat_o;
    logic        ack_i;
    logic [31:0] dat_i;

    modport master (
        output cyc_o, stb_o, we_o, adr_o, dat_o,
        input  ack_i, dat_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o, dat_o,
        output ack_i, dat_i
    );
endinterface

// File: rtl/semalock_master.sv
// Bus-master front end for the binary semaphore memory: write-then-readback
// lock/unlock with verification, exponential-backoff retry and ack watchdog.
module semalock_master #(
    parameter int unsigned MAX_TRIES    = 16,
    parameter int unsigned BACKOFF_INIT = 4,
    parameter int unsigned BACKOFF_MAX  = 256,
    parameter int unsigned ACK_TIMEOUT  = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        op_i,
    input  logic [9:0]  sem_i,
    input  logic [23:0] key_i,
    input  logic        abort_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        ok_o,
    output logic        err_o,
    output logic [7:0]  tries_o,
    semalock_master_if.master bus
);

    localparam int unsigned BW = $clog2(BACKOFF_MAX) + 1;
    localparam int unsigned WW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [BW-1:0] BO_INIT = BW'(BACKOFF_INIT);
    localparam logic [BW-1:0] BO_MAX  = BW'(BACKOFF_MAX);
    localparam logic [BW-1:0] BO_HALF = BW'(BACKOFF_MAX / 2);
    localparam logic [WW-1:0] WD_LAST = WW'(ACK_TIMEOUT - 1);
    localparam bit            FOREVER = (MAX_TRIES == 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_GAP,
        S_RD,
        S_CHK,
        S_BACKOFF,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic          op_q;
    logic [9:0]    sem_q;
    logic [23:0]   key_q;
    logic [7:0]    tries_q;
    logic [BW-1:0] bo_q;
    logic [BW-1:0] bo_cnt_q;
    logic [WW-1:0] wd_q;
    logic [31:0]   rdat_q;
    logic          ok_q;
    logic          err_q;

    logic capture;
    logic wr_ack;
    logic rd_ack;
    logic bo_load;
    logic bo_dec;
    logic wd_clr;
    logic wd_inc;
    logic set_res;
    logic res_ok;
    logic res_err;
    logic lock_hit;
    logic unlock_hit;
    logic out_of_tries;

    assign lock_hit     = (rdat_q[23:0] == key_q);
    assign unlock_hit   = (rdat_q == 32'h0);
    assign out_of_tries = !FOREVER && (32'(tries_q) >= MAX_TRIES);

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        wr_ack  = 1'b0;
        rd_ack  = 1'b0;
        bo_load = 1'b0;
        bo_dec  = 1'b0;
        wd_clr  = 1'b0;
        wd_inc  = 1'b0;
        set_res = 1'b0;
        res_ok  = 1'b0;
        res_err = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    capture = 1'b1;
                    wd_clr  = 1'b1;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (bus.ack_i) begin
                    wr_ack  = 1'b1;
                    wd_clr  = 1'b1;
                    state_d = S_GAP;
                end else if (wd_q == WD_LAST) begin
                    set_res = 1'b1;
                    res_err = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            // cyc low for one cycle so the slave sees its select drop
            S_GAP: begin
                wd_clr  = 1'b1;
                state_d = S_RD;
            end
            S_RD: begin
                if (bus.ack_i) begin
                    rd_ack  = 1'b1;
                    wd_clr  = 1'b1;
                    state_d = S_CHK;
                end else if (wd_q == WD_LAST) begin
                    set_res = 1'b1;
                    res_err = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            S_CHK: begin
                if (op_q) begin
                    set_res = 1'b1;
                    res_ok  = unlock_hit;
                    state_d = S_DONE;
                end else if (lock_hit) begin
                    set_res = 1'b1;
                    res_ok  = 1'b1;
                    state_d = S_DONE;
                end else if (out_of_tries) begin
                    set_res = 1'b1;
                    state_d = S_DONE;
                end else begin
                    bo_load = 1'b1;
                    state_d = S_BACKOFF;
                end
            end
            S_BACKOFF: begin
                if (abort_i) begin
                    set_res = 1'b1;
                    state_d = S_DONE;
                end else if (bo_cnt_q == '0) begin
                    wd_clr  = 1'b1;
                    state_d = S_WR;
                end else begin
                    bo_dec = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            op_q     <= 1'b0;
            sem_q    <= '0;
            key_q    <= '0;
            tries_q  <= '0;
            bo_q     <= '0;
            bo_cnt_q <= '0;
            wd_q     <= '0;
            rdat_q   <= '0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                op_q    <= op_i;
                sem_q   <= sem_i;
                key_q   <= key_i;
                tries_q <= '0;
                bo_q    <= BO_INIT;
            end
            if (wr_ack && tries_q != 8'hFF) begin
                tries_q <= tries_q + 8'd1;
            end
            if (rd_ack) begin
                rdat_q <= bus.dat_i;
            end
            if (wd_clr) begin
                wd_q <= '0;
            end else if (wd_inc) begin
                wd_q <= wd_q + WW'(1);
            end
            // count runs backoff-1..0 so BACKOFF lasts exactly backoff cycles
            if (bo_load) begin
                bo_cnt_q <= bo_q - BW'(1);
                bo_q     <= (bo_q >= BO_HALF) ? BO_MAX : (bo_q << 1);
            end else if (bo_dec) begin
                bo_cnt_q <= bo_cnt_q - BW'(1);
            end
            if (set_res) begin
                ok_q  <= res_ok;
                err_q <= res_err;
            end
        end
    end

    logic in_cycle;
    assign in_cycle = (state_q == S_WR) || (state_q == S_RD);

    // Bus outputs decode straight from the state flop so reset drops them at once
    assign bus.cyc_o = in_cycle;
    assign bus.stb_o = in_cycle;
    assign bus.we_o  = (state_q == S_WR);
    assign bus.adr_o = in_cycle ? {1'b0, op_q, sem_q, 2'b00} : 14'h0;
    assign bus.dat_o = (state_q == S_WR) ? {8'h00, key_q} : 32'h0;

    assign busy_o  = (state_q != S_IDLE);
    assign done_o  = (state_q == S_DONE);
    assign ok_o    = ok_q;
    assign err_o   = err_q;
    assign tries_o = tries_q;

endmodule
